countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
- Count-down counterpart to the team's up-counting stopwatch.
- Loads a preset M:SS.T (minutes 0-9, seconds 00-59, tenths 0-9) and decrements it once per 10 Hz tick.
- Supports start/pause, clear and an end-of-count alarm.
- Takes already debounced one-pulse inputs and an external 10 Hz enable from a clock divider.
- Drives four BCD digits into the existing 7-segment scan/decoder path.

Parameters:
- ALARM_TICKS, 20, number of tick pulses the alarm stays high in DONE (20 = 2 s).

Ports:
- clk  input  1  system clock; the only clock.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-cycle enable pulse, 10 Hz.
- start  input  1  one-cycle pulse; start/pause toggle, alarm acknowledge.
- clear  input  1  one-cycle pulse; abort and return to IDLE.
- preset_min  input  4  preset minutes, BCD.
- preset_sec_t  input  3  preset seconds tens, BCD.
- preset_sec_o  input  4  preset seconds ones, BCD.
- preset_ten  input  4  preset tenths, BCD.
- minute  output  4  current minutes digit.
- sec_tens  output  3  current seconds tens digit.
- sec_ones  output  4  current seconds ones digit.
- tenth  output  4  current tenths digit.
- running  output  1  high in RUN.
- done  output  1  one-cycle pulse on reaching zero.
- alarm  output  1  high throughout DONE.

Behaviour:
- Reset (rst_n=0, async): state IDLE; all digits 0; running, done, alarm 0; alarm counter 0.
- All outputs are registered. Any effect of an input appears the cycle after it is sampled.
- Preset clamp:
  - preset_min, preset_sec_o or preset_ten >9 -> 9.
  - preset_sec_t >5 -> 5.
- IDLE:
  - Digits load the clamped preset every cycle.
  - start with nonzero clamped preset -> RUN.
  - start with all-zero preset -> ignored, stay IDLE.
- RUN, on tick, BCD decrement with borrow chain:
  - tenth: 0 -> 9 with borrow.
  - sec_ones: 0 -> 9 with borrow.
  - sec_tens: 0 -> 5 with borrow.
  - minute: decrements.
  - If the value before the tick is 0:00.1: digits become 0:00.0, state -> DONE, done=1 for exactly that one cycle.
  - No wrap past zero, ever.
  - start (no tick) -> PAUSE.
  - start and tick in the same cycle: the decrement is applied, then -> PAUSE.
  - If that decrement reaches zero, DONE wins and the start is consumed.
- PAUSE:
  - Digits frozen; tick ignored.
  - start -> RUN.
  - The preset is NOT reloaded.
- DONE:
  - Digits held at 0; alarm=1.
  - Alarm counter counts ticks. After ALARM_TICKS ticks -> IDLE, alarm=0, counter cleared.
  - start -> IDLE immediately (acknowledge).
- clear: from any state -> IDLE next cycle. Priority: clear > start > tick.
- Preset changes while in RUN, PAUSE or DONE have no effect.
- Async reset mid-count: immediate return to reset values, no done pulse.
- running is 1 iff state is RUN, registered together with the state.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, DONE=2'd3.
  - Digit max constants: DIG_MAX=9, SECT_MAX=5.
  - Tick rate constant TICK_HZ=10.
- One natural sub-module, bcd_digit_dec:
  - Parameter MAX.
  - Inputs: value, dec_en. Outputs: next_value, borrow_out.
  - Instantiated four times in a borrow chain.
- State machine and alarm counter live in the top.

Test Plan:
- Reset, then preset 1:00.0, start, 10 ticks -> digits 0:59.0; running=1; done=0.
- Preset 0:00.3, start, 3 ticks -> after the 3rd tick: digits 0:00.0, done high for exactly 1 cycle, alarm=1. Then 20 more ticks -> IDLE, alarm=0, digits = preset.
- RUN at 2:30.5, start together with tick -> 2:30.4 and PAUSE. 5 further ticks -> still 2:30.4. start -> RUN, next tick -> 2:30.3.
- Preset sec_t=7, ten=12 -> IDLE digits show sec_tens=5, tenth=9. Preset 0:00.0 plus start -> stays IDLE, running=0.
- clear and start in the same cycle during RUN at 4:12.7 -> IDLE next cycle, digits = preset, running=0. During DONE, start -> IDLE with alarm=0 on the next cycle.
- Assert rst_n=0 asynchronously mid-RUN between clock edges -> outputs go to 0 immediately without waiting for an edge; no done pulse after release.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the M:SS.T countdown timer.
// FSM state encoding, digit limits, and the preset clamp helper.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0] DIG_MAX  = 4'd9;
    localparam logic [3:0] SECT_MAX = 4'd5;
    localparam int         TICK_HZ  = 10;

    function automatic logic [3:0] clamp_dig(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/preset inputs and BCD/status outputs of the countdown timer.
// slave = timer side, master = controller/display side.
interface countdown_timer_if;
    logic       tick;
    logic       start;
    logic       clear;
    logic [3:0] preset_min;
    logic [2:0] preset_sec_t;
    logic [3:0] preset_sec_o;
    logic [3:0] preset_ten;
    logic [3:0] minute;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenth;
    logic       running;
    logic       done;
    logic       alarm;

    modport slave (
        input  tick, start, clear, preset_min, preset_sec_t, preset_sec_o, preset_ten,
        output minute, sec_tens, sec_ones, tenth, running, done, alarm
    );

    modport master (
        output tick, start, clear, preset_min, preset_sec_t, preset_sec_o, preset_ten,
        input  minute, sec_tens, sec_ones, tenth, running, done, alarm
    );
endinterface

// File: rtl/countdown_timer_bcd_digit_dec.sv
// One BCD digit decrementer: wraps 0 -> MAX and raises borrow_out when enabled.
// Purely combinational; no handshake.
module bcd_digit_dec #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = W'(9)
) (
    input  logic [W-1:0] value,
    input  logic         dec_en,
    output logic [W-1:0] next_value,
    output logic         borrow_out
);
    always_comb begin
        next_value = value;
        borrow_out = 1'b0;
        if (dec_en) begin
            if (value == '0) begin
                next_value = MAX;
                borrow_out = 1'b1;
            end else begin
                next_value = value - W'(1);
            end
        end
    end
endmodule

// File: rtl/countdown_timer.sv
// M:SS.T countdown with start/pause, clear and timed alarm; outputs registered, 1-cycle latency.
// No backpressure: tick/start/clear are single-cycle pulses acted on when sampled.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int ALARM_TICKS = 2 * TICK_HZ
) (
    input  logic              clk,
    input  logic              rst_n,
    countdown_timer_if.slave  bus
);
    localparam int CW = $clog2(ALARM_TICKS + 1);

    state_e        state_q;
    logic [3:0]    min_q, sec_o_q, ten_q;
    logic [2:0]    sec_t_q;
    logic          running_q, done_q, alarm_q;
    logic [CW-1:0] alm_cnt_q;

    logic [3:0] min_cl, sec_o_cl, ten_cl;
    logic [2:0] sec_t_cl;
    logic       preset_zero;

    logic [3:0] min_d, sec_o_d, ten_d;
    logic [2:0] sec_t_d;
    logic       b_ten, b_sec_o, b_sec_t, b_min;
    logic       dec_zero;

    assign min_cl      = clamp_dig(bus.preset_min, DIG_MAX);
    assign sec_o_cl    = clamp_dig(bus.preset_sec_o, DIG_MAX);
    assign ten_cl      = clamp_dig(bus.preset_ten, DIG_MAX);
    assign sec_t_cl    = (bus.preset_sec_t > SECT_MAX[2:0]) ? SECT_MAX[2:0] : bus.preset_sec_t;
    assign preset_zero = (min_cl == 4'd0) && (sec_t_cl == 3'd0) && (sec_o_cl == 4'd0) && (ten_cl == 4'd0);

    bcd_digit_dec #(.W(4), .MAX(DIG_MAX)) u_ten (
        .value(ten_q), .dec_en(1'b1), .next_value(ten_d), .borrow_out(b_ten)
    );
    bcd_digit_dec #(.W(4), .MAX(DIG_MAX)) u_sec_o (
        .value(sec_o_q), .dec_en(b_ten), .next_value(sec_o_d), .borrow_out(b_sec_o)
    );
    bcd_digit_dec #(.W(3), .MAX(SECT_MAX[2:0])) u_sec_t (
        .value(sec_t_q), .dec_en(b_sec_o), .next_value(sec_t_d), .borrow_out(b_sec_t)
    );
    bcd_digit_dec #(.W(4), .MAX(DIG_MAX)) u_min (
        .value(min_q), .dec_en(b_sec_t), .next_value(min_d), .borrow_out(b_min)
    );

    assign dec_zero = (min_d == 4'd0) && (sec_t_d == 3'd0) && (sec_o_d == 4'd0) && (ten_d == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            min_q     <= '0;
            sec_t_q   <= '0;
            sec_o_q   <= '0;
            ten_q     <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
            alm_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.clear) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
                alarm_q   <= 1'b0;
                alm_cnt_q <= '0;
                {min_q, sec_t_q, sec_o_q, ten_q} <= {min_cl, sec_t_cl, sec_o_cl, ten_cl};
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        {min_q, sec_t_q, sec_o_q, ten_q} <= {min_cl, sec_t_cl, sec_o_cl, ten_cl};
                        if (bus.start && !preset_zero) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        // b_min can only fire at 0:00.0, which RUN never holds; guard anyway.
                        if (bus.tick && !b_min) begin
                            {min_q, sec_t_q, sec_o_q, ten_q} <= {min_d, sec_t_d, sec_o_d, ten_d};
                            if (dec_zero) begin
                                state_q   <= ST_DONE;
                                running_q <= 1'b0;
                                done_q    <= 1'b1;
                                alarm_q   <= 1'b1;
                                alm_cnt_q <= '0;
                            end else if (bus.start) begin
                                state_q   <= ST_PAUSE;
                                running_q <= 1'b0;
                            end
                        end else if (bus.start) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (bus.start) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        if (bus.start || (bus.tick && alm_cnt_q == CW'(ALARM_TICKS - 1))) begin
                            state_q   <= ST_IDLE;
                            alarm_q   <= 1'b0;
                            alm_cnt_q <= '0;
                            {min_q, sec_t_q, sec_o_q, ten_q} <= {min_cl, sec_t_cl, sec_o_cl, ten_cl};
                        end else if (bus.tick) begin
                            alm_cnt_q <= alm_cnt_q + CW'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.minute   = min_q;
    assign bus.sec_tens = sec_t_q;
    assign bus.sec_ones = sec_o_q;
    assign bus.tenth    = ten_q;
    assign bus.running  = running_q;
    assign bus.done     = done_q;
    assign bus.alarm    = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with hand-computed expectations.
module tb_countdown_timer;
    logic clk;
    logic rst_n;
    int   vectors     = 0;
    int   miscompares = 0;

    countdown_timer_if bus();

    countdown_timer #(.ALARM_TICKS(20)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dig(input string tag, input logic [3:0] m, input logic [2:0] st,
                           input logic [3:0] so, input logic [3:0] t);
        chk(tag, {17'b0, bus.minute, bus.sec_tens, bus.sec_ones, bus.tenth}, {17'b0, m, st, so, t});
    endtask

    task automatic set_preset(input logic [3:0] m, input logic [2:0] st,
                              input logic [3:0] so, input logic [3:0] t);
        bus.preset_min   = m;
        bus.preset_sec_t = st;
        bus.preset_sec_o = so;
        bus.preset_ten   = t;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
    endtask

    task automatic pulse_tick();
        bus.tick = 1'b1;
        cyc();
        bus.tick = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        cyc();
        bus.clear = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.clear = 1'b0;
        set_preset(4'd0, 3'd0, 4'd0, 4'd0);

        // Reset state
        cyc();
        cyc();
        chk_dig("rst_digits", 4'd0, 3'd0, 4'd0, 4'd0);
        chk("rst_running", 32'(bus.running), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_alarm", 32'(bus.alarm), 32'd0);
        rst_n = 1'b1;

        // 1:00.0 minus 10 ticks
        set_preset(4'd1, 3'd0, 4'd0, 4'd0);
        cyc();
        chk_dig("idle_load", 4'd1, 3'd0, 4'd0, 4'd0);
        pulse_start();
        chk("start_running", 32'(bus.running), 32'd1);
        pulse_tick();
        chk_dig("borrow_chain", 4'd0, 3'd5, 4'd9, 4'd9);
        for (int i = 0; i < 9; i++) pulse_tick();
        chk_dig("ten_ticks", 4'd0, 3'd5, 4'd9, 4'd0);
        chk("ten_ticks_running", 32'(bus.running), 32'd1);
        chk("ten_ticks_done", 32'(bus.done), 32'd0);

        // 0:00.3 to zero, done pulse, alarm timeout
        pulse_clear();
        chk_dig("clear_reload", 4'd1, 3'd0, 4'd0, 4'd0);
        set_preset(4'd0, 3'd0, 4'd0, 4'd3);
        cyc();
        pulse_start();
        for (int i = 0; i < 3; i++) pulse_tick();
        chk_dig("zero_digits", 4'd0, 3'd0, 4'd0, 4'd0);
        chk("zero_done", 32'(bus.done), 32'd1);
        chk("zero_alarm", 32'(bus.alarm), 32'd1);
        chk("zero_running", 32'(bus.running), 32'd0);
        cyc();
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        chk("alarm_held", 32'(bus.alarm), 32'd1);
        for (int i = 0; i < 19; i++) pulse_tick();
        chk("alarm_19_ticks", 32'(bus.alarm), 32'd1);
        chk_dig("done_digits_zero", 4'd0, 3'd0, 4'd0, 4'd0);
        pulse_tick();
        chk("alarm_timeout", 32'(bus.alarm), 32'd0);
        chk_dig("timeout_preset", 4'd0, 3'd0, 4'd0, 4'd3);
        chk("timeout_running", 32'(bus.running), 32'd0);

        // start together with tick pauses after the decrement
        set_preset(4'd2, 3'd3, 4'd0, 4'd5);
        cyc();
        pulse_start();
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        chk_dig("start_tick_dec", 4'd2, 3'd3, 4'd0, 4'd4);
        chk("start_tick_pause", 32'(bus.running), 32'd0);
        for (int i = 0; i < 5; i++) pulse_tick();
        chk_dig("pause_frozen", 4'd2, 3'd3, 4'd0, 4'd4);
        set_preset(4'd7, 3'd1, 4'd1, 4'd1);
        pulse_start();
        chk("resume_running", 32'(bus.running), 32'd1);
        chk_dig("resume_no_reload", 4'd2, 3'd3, 4'd0, 4'd4);
        pulse_tick();
        chk_dig("resume_tick", 4'd2, 3'd3, 4'd0, 4'd3);

        // Preset clamping and zero preset
        set_preset(4'hF, 3'd7, 4'hA, 4'hC);
        pulse_clear();
        chk_dig("clamp_all", 4'd9, 3'd5, 4'd9, 4'd9);
        set_preset(4'd0, 3'd0, 4'd0, 4'd0);
        cyc();
        pulse_start();
        chk("zero_preset_ignored", 32'(bus.running), 32'd0);
        chk_dig("zero_preset_digits", 4'd0, 3'd0, 4'd0, 4'd0);

        // clear beats start during RUN
        set_preset(4'd4, 3'd1, 4'd2, 4'd7);
        cyc();
        pulse_start();
        pulse_tick();
        chk_dig("run_4127", 4'd4, 3'd1, 4'd2, 4'd6);
        bus.clear = 1'b1;
        bus.start = 1'b1;
        cyc();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk_dig("clear_start_digits", 4'd4, 3'd1, 4'd2, 4'd7);
        chk("clear_start_running", 32'(bus.running), 32'd0);

        // DONE wins over start at zero; start acknowledges alarm
        set_preset(4'd0, 3'd0, 4'd0, 4'd1);
        cyc();
        pulse_start();
        bus.start = 1'b1;
        bus.tick  = 1'b1;
        cyc();
        bus.start = 1'b0;
        bus.tick  = 1'b0;
        chk("done_wins_done", 32'(bus.done), 32'd1);
        chk("done_wins_alarm", 32'(bus.alarm), 32'd1);
        pulse_start();
        chk("ack_alarm", 32'(bus.alarm), 32'd0);
        chk("ack_running", 32'(bus.running), 32'd0);
        chk_dig("ack_preset", 4'd0, 3'd0, 4'd0, 4'd1);

        // Asynchronous reset mid-count
        set_preset(4'd5, 3'd0, 4'd0, 4'd0);
        cyc();
        pulse_start();
        pulse_tick();
        chk_dig("pre_arst", 4'd4, 3'd5, 4'd9, 4'd9);
        #2;
        rst_n = 1'b0;
        #1;
        chk_dig("arst_digits", 4'd0, 3'd0, 4'd0, 4'd0);
        chk("arst_running", 32'(bus.running), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse_tick();
            chk("arst_no_done", 32'(bus.done), 32'd0);
        end
        chk("arst_idle", 32'(bus.running), 32'd0);
        chk_dig("arst_reload", 4'd5, 3'd0, 4'd0, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
